// File: rtl/rvfi_pkg.sv
// Shared RVFI shadow-pipeline types: the payload captured per instruction
// and the default data/address width.
package rvfi_pkg;

  localparam int XLEN   = 32;
  localparam int MASK_W = XLEN / 8;

  typedef struct packed {
    logic [31:0]       inst;
    logic [XLEN-1:0]   pc;
    logic [4:0]        rs1_addr;
    logic [4:0]        rs2_addr;
    logic [XLEN-1:0]   rs1_rdata;
    logic [XLEN-1:0]   rs2_rdata;
    logic [XLEN-1:0]   mem_addr;
    logic [MASK_W-1:0] mem_rmask;
    logic [MASK_W-1:0] mem_wmask;
    logic [XLEN-1:0]   mem_rdata;
    logic [XLEN-1:0]   mem_wdata;
  } rvfi_payload_t;

endpackage

// File: rtl/rvfi_shadow_stage.sv
// One shadow-pipeline register stage: valid bit, payload and next-PC, with
// flush > stall > load priority and bubble insertion behind a stalled stage.
module rvfi_shadow_stage #(
  parameter int XLEN = rvfi_pkg::XLEN
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   stall_prev,
  input  logic                   flush,
  input  logic                   in_valid,
  input  rvfi_pkg::rvfi_payload_t in_payload,
  input  logic [XLEN-1:0]        in_pc_wdata,
  output logic                   valid,
  output rvfi_pkg::rvfi_payload_t payload,
  output logic [XLEN-1:0]        pc_wdata
);

  // A stalled upstream stage keeps its entry, so this stage must take a
  // bubble rather than a copy of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid    <= 1'b0;
      payload  <= '0;
      pc_wdata <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!stall) begin
      valid    <= in_valid & ~stall_prev;
      payload  <= in_payload;
      pc_wdata <= in_pc_wdata;
    end
  end

endmodule

// File: rtl/rvfi_shadow_pipe.sv
// Shadow pipeline carrying RVFI retirement info from capture to commit,
// with a retire-order counter and self-loop halt detection.
module rvfi_shadow_pipe #(
  parameter int DEPTH   = 2,
  parameter int XLEN    = rvfi_pkg::XLEN,
  parameter int ORDER_W = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cap_valid,
  input  rvfi_pkg::rvfi_payload_t cap_payload,
  input  logic                    cap_br_taken,
  input  logic [XLEN-1:0]         cap_br_target,
  input  logic [DEPTH-1:0]        stall,
  input  logic [DEPTH-1:0]        flush,
  input  logic                    wb_load,
  input  logic [XLEN-1:0]         wb_rd_wdata,
  output logic                    commit,
  output logic [ORDER_W-1:0]      order,
  output rvfi_pkg::rvfi_payload_t out_payload,
  output logic [XLEN-1:0]         pc_wdata,
  output logic [XLEN-1:0]         rd_wdata,
  output logic                    halt,
  output logic                    halted
);

  logic [XLEN-1:0]         cap_pc;
  logic [XLEN-1:0]         cap_pc_wdata;
  logic [DEPTH-1:0]        stage_valid;
  rvfi_pkg::rvfi_payload_t stage_payload [DEPTH];
  logic [XLEN-1:0]         stage_pc_wdata [DEPTH];
  logic [XLEN-1:0]         last_pc;

  assign cap_pc       = XLEN'(cap_payload.pc);
  assign cap_pc_wdata = cap_br_taken ? cap_br_target : (cap_pc + XLEN'(4));

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      rvfi_shadow_stage #(.XLEN(XLEN)) u_stage (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall[i]),
        .stall_prev  (1'b0),
        .flush       (flush[i]),
        .in_valid    (cap_valid),
        .in_payload  (cap_payload),
        .in_pc_wdata (cap_pc_wdata),
        .valid       (stage_valid[i]),
        .payload     (stage_payload[i]),
        .pc_wdata    (stage_pc_wdata[i])
      );
    end else begin : g_body
      rvfi_shadow_stage #(.XLEN(XLEN)) u_stage (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall[i]),
        .stall_prev  (stall[i-1]),
        .flush       (flush[i]),
        .in_valid    (stage_valid[i-1]),
        .in_payload  (stage_payload[i-1]),
        .in_pc_wdata (stage_pc_wdata[i-1]),
        .valid       (stage_valid[i]),
        .payload     (stage_payload[i]),
        .pc_wdata    (stage_pc_wdata[i])
      );
    end
  end

  // Gating with rst keeps commit low while reset is held, even before the
  // first reset edge has cleared the stage valid bits.
  assign commit      = stage_valid[DEPTH-1] & ~stall[DEPTH-1] & ~flush[DEPTH-1] & rst;
  assign out_payload = stage_payload[DEPTH-1];
  assign pc_wdata    = stage_pc_wdata[DEPTH-1];
  assign last_pc     = XLEN'(stage_payload[DEPTH-1].pc);
  assign halt        = commit & (stage_pc_wdata[DEPTH-1] == last_pc);
  assign rd_wdata    = wb_load ? wb_rd_wdata : '0;

  always_ff @(posedge clk) begin
    if (!rst) begin
      order  <= '0;
      halted <= 1'b0;
    end else begin
      if (commit) order <= order + ORDER_W'(1);
      if (halt) halted <= 1'b1;
    end
  end

endmodule
